// File: rtl/reg_mem_ctx_store_if.sv
// reg_mem_ctx_store_if
//   Bundles the request strobes from the register memory controller, the
//   register file read/write port and the transfer status outputs of
//   reg_mem_ctx_store.
//
//   Signals:
//     RM_write  save request (level) from the register memory controller
//     RM_read   restore request (level) from the register memory controller
//     CTX_ID    target context slot
//     RF_RADDR  register file read address (save)
//     RF_RDATA  register file combinational read data for RF_RADDR
//     RF_WADDR  register file write address (restore)
//     RF_WDATA  register file write data
//     RF_WEN    register file write enable
//     BUSY      transfer in progress
//     DONE      one-cycle completion pulse
//     ERR       one-cycle pulse with DONE when a restore hit an unwritten slot
//
//   Modports:
//     master  controller / register file side
//     slave   the context store
interface reg_mem_ctx_store_if #(
    parameter int CTX_W = 2,
    parameter int XLEN  = 32
);
    logic             RM_write;
    logic             RM_read;
    logic [CTX_W-1:0] CTX_ID;
    logic [4:0]       RF_RADDR;
    logic [XLEN-1:0]  RF_RDATA;
    logic [4:0]       RF_WADDR;
    logic [XLEN-1:0]  RF_WDATA;
    logic             RF_WEN;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        output RM_write, RM_read, CTX_ID, RF_RDATA,
        input  RF_RADDR, RF_WADDR, RF_WDATA, RF_WEN, BUSY, DONE, ERR
    );

    modport slave (
        input  RM_write, RM_read, CTX_ID, RF_RDATA,
        output RF_RADDR, RF_WADDR, RF_WDATA, RF_WEN, BUSY, DONE, ERR
    );
endinterface

// File: rtl/reg_mem_ctx_store.sv
// reg_mem_ctx_store
//   Register memory transfer sequencer. A rising RM_write saves x1..x31 from
//   the register file into context slot CTX_ID; a rising RM_read restores
//   x1..x31 from that slot back into the register file. x0 is never touched.
//
//   Ports:
//     CLK    clock, all state updates on the rising edge
//     RESET  synchronous active-high reset
//     bus    reg_mem_ctx_store_if.slave (requests, register file port, status)
//
//   Timing (request first high in cycle c):
//     the request is registered twice and the 0->1 step between the two copies
//     is the start edge, so BUSY rises in cycle c+2. Save occupies c+2..c+32,
//     restore c+2..c+33 (read stage plus one drain cycle), and the DONE pulse
//     lands in cycle c+33 for a save and c+34 for a restore.
module reg_mem_ctx_store #(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = 2,
    parameter int XLEN    = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    reg_mem_ctx_store_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_FIN
    } state_t;

    localparam logic [4:0] LAST_REG = 5'd31;

    state_t state;
    state_t state_nxt;

    // Request edge detection: two registered copies of each strobe.
    logic write_d1;
    logic write_d2;
    logic read_d1;
    logic read_d2;
    logic write_rise;
    logic read_rise;

    logic [CTX_W-1:0]   ctx_q;
    logic [4:0]         idx;
    logic               drain_q;
    logic               err_q;
    logic [NUM_CTX-1:0] valid;

    // Restore write stage registers.
    logic [XLEN-1:0]    rd_q;
    logic [4:0]         waddr_q;
    logic               wen_q;

    // Slot-major storage addressed by {ctx, reg}; entry reg=0 is never used.
    logic [XLEN-1:0]    mem [NUM_CTX*32];

    logic               busy;
    logic               done;
    logic               err;
    logic [4:0]         raddr;

    assign write_rise = write_d1 & ~write_d2;
    assign read_rise  = read_d1 & ~read_d2;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        raddr     = 5'd0;

        unique case (state)
            ST_IDLE: begin
                // Save wins when both requests rise together.
                if (write_rise) begin
                    state_nxt = ST_SAVE;
                end else if (read_rise) begin
                    state_nxt = ST_RESTORE;
                end
            end
            ST_SAVE: begin
                busy  = 1'b1;
                raddr = idx;
                if (idx == LAST_REG) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_RESTORE: begin
                busy = 1'b1;
                if (drain_q) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                err       = err_q;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: edge registers, slot index, register walk, restore pipe
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            write_d1 <= 1'b0;
            write_d2 <= 1'b0;
            read_d1  <= 1'b0;
            read_d2  <= 1'b0;
            ctx_q    <= '0;
            idx      <= 5'd0;
            drain_q  <= 1'b0;
            err_q    <= 1'b0;
            valid    <= '0;
            rd_q     <= '0;
            waddr_q  <= 5'd0;
            wen_q    <= 1'b0;
        end else begin
            // Edge registers track the inputs in every state, so a level
            // held across a transfer never looks like a fresh request.
            write_d1 <= bus.RM_write;
            write_d2 <= write_d1;
            read_d1  <= bus.RM_read;
            read_d2  <= read_d1;
            wen_q    <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (write_rise || read_rise) begin
                        ctx_q   <= bus.CTX_ID;
                        idx     <= 5'd1;
                        drain_q <= 1'b0;
                        // Only a restore can fail, and only on an unwritten slot.
                        err_q   <= ~write_rise & ~valid[bus.CTX_ID];
                    end
                end
                ST_SAVE: begin
                    if (idx == LAST_REG) begin
                        valid[ctx_q] <= 1'b1;
                        idx          <= 5'd0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                ST_RESTORE: begin
                    if (!drain_q) begin
                        rd_q    <= err_q ? '0 : mem[{ctx_q, idx}];
                        waddr_q <= idx;
                        wen_q   <= 1'b1;
                        // Stop at x31 and spend one cycle draining the write
                        // stage instead of letting idx wrap to x0.
                        if (idx == LAST_REG) begin
                            drain_q <= 1'b1;
                            idx     <= 5'd0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end else begin
                        rd_q    <= '0;
                        waddr_q <= 5'd0;
                    end
                end
                ST_FIN: begin
                    err_q   <= 1'b0;
                    drain_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the context array has no reset; VALID decides whether a slot's
    // contents may be used, so clearing the storage itself is unnecessary.
    always_ff @(posedge CLK) begin
        if (!RESET && state == ST_SAVE) begin
            mem[{ctx_q, idx}] <= bus.RF_RDATA;
        end
    end

    assign bus.BUSY     = busy;
    assign bus.DONE     = done;
    assign bus.ERR      = err;
    assign bus.RF_RADDR = raddr;
    assign bus.RF_WEN   = wen_q;
    assign bus.RF_WADDR = waddr_q;
    assign bus.RF_WDATA = rd_q;

endmodule

// File: tb/tb_reg_mem_ctx_store.sv
// tb_reg_mem_ctx_store
//   Drives reg_mem_ctx_store through save, restore, invalid-slot restore,
//   simultaneous requests, held requests and reset mid-transfer, against a
//   register file model and a per-slot context model. Expected register file
//   reads and writes are queued when a request is issued and popped when the
//   DUT's traffic is compared.
module tb_reg_mem_ctx_store;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    reg_mem_ctx_store_if #(.CTX_W(2), .XLEN(32)) bus ();

    reg_mem_ctx_store #(
        .NUM_CTX(4),
        .CTX_W  (2),
        .XLEN   (32)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    // Register file model: combinational read, clocked write.
    logic [31:0] rf [32];
    logic        rf_load = 1'b0;
    logic        rf_zero = 1'b0;
    logic [31:0] rf_base = 32'h0;

    assign bus.RF_RDATA = rf[bus.RF_RADDR];

    always @(posedge CLK) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_zero ? 32'h0 : rf_base + 32'(i);
        end else if (bus.RF_WEN) begin
            rf[bus.RF_WADDR] <= bus.RF_WDATA;
        end
    end

    // Context model.
    logic [31:0] mem_m [4][32];
    logic [3:0]  valid_m;

    // Scoreboard queues.
    logic [4:0]  exp_rd[$];
    logic [4:0]  obs_rd[$];
    logic [36:0] exp_wr[$];
    logic [36:0] obs_wr[$];

    // Observations from the last watch() run (cycle numbers relative to the
    // cycle in which the request was raised).
    int first_busy, last_busy, busy_n;
    int done_k, done_n, err_k, err_n;
    int wen_n, wen0_n;

    int total = 0;
    int bad   = 0;

    task automatic load_rf(input logic zero, input logic [31:0] base);
        @(negedge CLK);
        rf_zero = zero;
        rf_base = base;
        rf_load = 1'b1;
        @(negedge CLK);
        rf_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        bus.RM_write = 1'b0;
        bus.RM_read  = 1'b0;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        valid_m = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic expect_save(input int ctx);
        for (int i = 1; i < 32; i++) begin
            exp_rd.push_back(5'(i));
            mem_m[ctx][i] = rf[i];
        end
        valid_m[ctx] = 1'b1;
    endtask

    task automatic expect_restore(input int ctx);
        for (int i = 1; i < 32; i++) begin
            exp_wr.push_back({5'(i), valid_m[ctx] ? mem_m[ctx][i] : 32'h0});
        end
    endtask

    task automatic start_req(input logic w, input logic r, input logic [1:0] ctx);
        @(negedge CLK);
        bus.CTX_ID   = ctx;
        bus.RM_write = w;
        bus.RM_read  = r;
    endtask

    // Runs max_k cycles after start_req, recording outputs at each negedge and
    // then applying the scripted input changes for that cycle (0 disables).
    task automatic watch(input int max_k, input int drop_k, input int poke_k,
                         input int rst_k, input logic [1:0] ctx);
        first_busy = -1; last_busy = -1; busy_n = 0;
        done_k = -1; done_n = 0; err_k = -1; err_n = 0;
        wen_n = 0; wen0_n = 0;
        obs_rd.delete();
        obs_wr.delete();
        for (int k = 1; k <= max_k; k++) begin
            @(negedge CLK);
            if (bus.BUSY) begin
                busy_n++;
                last_busy = k;
                if (first_busy < 0) first_busy = k;
            end
            if (bus.RF_RADDR != 5'd0) obs_rd.push_back(bus.RF_RADDR);
            if (bus.DONE) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (bus.ERR) begin
                err_n++;
                if (err_k < 0) err_k = k;
            end
            if (bus.RF_WEN) begin
                wen_n++;
                if (bus.RF_WADDR == 5'd0) wen0_n++;
                obs_wr.push_back({bus.RF_WADDR, bus.RF_WDATA});
            end
            if (k == drop_k) begin
                bus.RM_write = 1'b0;
                bus.RM_read  = 1'b0;
            end
            if (k == poke_k)     bus.RM_read = 1'b1;
            if (k == poke_k + 3) bus.RM_read = 1'b0;
            if (k == 5)          bus.CTX_ID  = ~ctx;
            if (k == rst_k)      RESET = 1'b1;
            if (k == rst_k + 1)  RESET = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.RM_write = 1'b0;
        bus.RM_read  = 1'b0;
        bus.CTX_ID   = 2'd0;
        valid_m      = '0;
        repeat (3) @(negedge CLK);
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        total++; if (bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b exp=00", bus.DONE, bus.ERR); end
        total++; if (bus.RF_WEN !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", bus.RF_WEN); end
        total++; if (bus.RF_RADDR !== 5'd0 || bus.RF_WADDR !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", bus.RF_RADDR, bus.RF_WADDR); end
        total++; if (bus.RF_WDATA !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.RF_WDATA); end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", bus.BUSY); end
    endtask

    task automatic test_save();
        logic [4:0] e, o;
        load_rf(1'b0, 32'h1000_0000);
        expect_save(2);
        start_req(1'b1, 1'b0, 2'd2);
        watch(40, 1, 0, 0, 2'd2);
        total++; if (first_busy !== 2) begin bad++; $display("FAIL save_busy_start got=%0d exp=2", first_busy); end
        total++; if (done_k !== 33) begin bad++; $display("FAIL save_done_cycle got=%0d exp=33", done_k); end
        total++; if (done_n !== 1 || err_n !== 0) begin bad++; $display("FAIL save_done_err got=%0d/%0d exp=1/0", done_n, err_n); end
        total++; if (busy_n !== 32) begin bad++; $display("FAIL save_busy_len got=%0d exp=32", busy_n); end
        total++; if (wen_n !== 0) begin bad++; $display("FAIL save_wen got=%0d exp=0", wen_n); end
        total++; if (obs_rd.size() !== exp_rd.size()) begin bad++; $display("FAIL save_read_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = 5'd0;
            if (obs_rd.size() > 0) o = obs_rd.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL save_raddr got=%0d exp=%0d", o, e); end
        end
    endtask

    task automatic test_restore();
        logic [36:0] e, o;
        int rf_bad;
        load_rf(1'b1, 32'h0);
        expect_restore(2);
        start_req(1'b0, 1'b1, 2'd2);
        watch(40, 1, 0, 0, 2'd2);
        total++; if (first_busy !== 2) begin bad++; $display("FAIL rest_busy_start got=%0d exp=2", first_busy); end
        total++; if (done_k !== 34) begin bad++; $display("FAIL rest_done_cycle got=%0d exp=34", done_k); end
        total++; if (done_n !== 1 || err_n !== 0) begin bad++; $display("FAIL rest_done_err got=%0d/%0d exp=1/0", done_n, err_n); end
        total++; if (busy_n !== 33) begin bad++; $display("FAIL rest_busy_len got=%0d exp=33", busy_n); end
        total++; if (wen_n !== 31 || wen0_n !== 0) begin bad++; $display("FAIL rest_wen_count got=%0d/x0:%0d exp=31/0", wen_n, wen0_n); end
        total++; if (obs_rd.size() !== 0) begin bad++; $display("FAIL rest_reads got=%0d exp=0", obs_rd.size()); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = '0;
            if (obs_wr.size() > 0) o = obs_wr.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rest_write got=%0d:%h exp=%0d:%h", o[36:32], o[31:0], e[36:32], e[31:0]);
            end
        end
        rf_bad = 0;
        for (int i = 1; i < 32; i++) if (rf[i] !== 32'h1000_0000 + 32'(i)) rf_bad++;
        total++; if (rf_bad !== 0) begin bad++; $display("FAIL rest_rf_contents got=%0d wrong exp=0 wrong", rf_bad); end
        total++; if (rf[0] !== 32'h0) begin bad++; $display("FAIL rest_x0 got=%h exp=0", rf[0]); end
    endtask

    task automatic test_restore_invalid();
        logic [36:0] e, o;
        do_reset();
        load_rf(1'b0, 32'h5555_0000);
        expect_restore(1);
        start_req(1'b0, 1'b1, 2'd1);
        watch(40, 1, 0, 0, 2'd1);
        total++; if (done_k !== 34 || done_n !== 1) begin bad++; $display("FAIL inv_done got=%0d/%0d exp=34/1", done_k, done_n); end
        total++; if (err_k !== done_k || err_n !== 1) begin bad++; $display("FAIL inv_err got=%0d/%0d exp=%0d/1", err_k, err_n, done_k); end
        total++; if (wen_n !== 31 || wen0_n !== 0) begin bad++; $display("FAIL inv_wen_count got=%0d/x0:%0d exp=31/0", wen_n, wen0_n); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = '1;
            if (obs_wr.size() > 0) o = obs_wr.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL inv_write got=%0d:%h exp=%0d:%h", o[36:32], o[31:0], e[36:32], e[31:0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] e, o;
        load_rf(1'b0, 32'h2000_0000);
        expect_save(0);
        start_req(1'b1, 1'b1, 2'd0);
        // Second RM_read edge raised at cycle 10, mid-save.
        watch(45, 1, 10, 0, 2'd0);
        total++; if (done_n !== 1) begin bad++; $display("FAIL simul_done_count got=%0d exp=1", done_n); end
        total++; if (done_k !== 33) begin bad++; $display("FAIL simul_done_cycle got=%0d exp=33", done_k); end
        total++; if (wen_n !== 0 || err_n !== 0) begin bad++; $display("FAIL simul_wen_err got=%0d/%0d exp=0/0", wen_n, err_n); end
        total++; if (obs_rd.size() !== exp_rd.size()) begin bad++; $display("FAIL simul_read_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = 5'd0;
            if (obs_rd.size() > 0) o = obs_rd.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL simul_raddr got=%0d exp=%0d", o, e); end
        end
    endtask

    task automatic test_hold();
        load_rf(1'b0, 32'h3000_0000);
        expect_save(3);
        start_req(1'b1, 1'b0, 2'd3);
        watch(110, 100, 0, 0, 2'd3);
        total++; if (done_n !== 1) begin bad++; $display("FAIL hold_done_count got=%0d exp=1", done_n); end
        total++; if (obs_rd.size() !== 31) begin bad++; $display("FAIL hold_read_count got=%0d exp=31", obs_rd.size()); end
        exp_rd.delete();
        // Re-raising the request starts a second save into the same slot.
        expect_save(3);
        start_req(1'b1, 1'b0, 2'd3);
        watch(40, 1, 0, 0, 2'd3);
        total++; if (done_n !== 1 || done_k !== 33) begin bad++; $display("FAIL hold_second_save got=%0d@%0d exp=1@33", done_n, done_k); end
        total++; if (obs_rd.size() !== 31) begin bad++; $display("FAIL hold_second_reads got=%0d exp=31", obs_rd.size()); end
        exp_rd.delete();
    endtask

    task automatic test_reset_mid();
        logic [36:0] e, o;
        start_req(1'b1, 1'b0, 2'd3);
        watch(40, 1, 0, 10, 2'd3);
        valid_m = '0;
        total++; if (last_busy !== 10) begin bad++; $display("FAIL rmid_busy_end got=%0d exp=10", last_busy); end
        total++; if (done_n !== 0) begin bad++; $display("FAIL rmid_done got=%0d exp=0", done_n); end
        expect_restore(3);
        start_req(1'b0, 1'b1, 2'd3);
        watch(40, 1, 0, 0, 2'd3);
        total++; if (done_k !== 34 || err_k !== 34 || err_n !== 1) begin bad++; $display("FAIL rmid_err got=done@%0d err@%0d n=%0d exp=34/34/1", done_k, err_k, err_n); end
        total++; if (wen_n !== 31) begin bad++; $display("FAIL rmid_wen_count got=%0d exp=31", wen_n); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = '1;
            if (obs_wr.size() > 0) o = obs_wr.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rmid_write got=%0d:%h exp=%0d:%h", o[36:32], o[31:0], e[36:32], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_save();
        test_restore();
        test_restore_invalid();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_mem_ctx_store.md
Name: reg_mem_ctx_store

Overview:
- Register memory and transfer sequencer, directly downstream of the register memory controller.
- Consumes its RM_write (save) and RM_read (restore) strobes.
- Save: walks architectural registers x1..x31 out of the register file into one of NUM_CTX context slots.
- Restore: walks them back from the slot into the register file.
- Holds the saved contexts in an internal word array and reports completion and error status.

Parameters:
- NUM_CTX, 4, number of context slots; power of 2, at least 2.
- CTX_W, 2, width of context index; equals log2(NUM_CTX).
- XLEN, 32, register data width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- RM_write  input  1  save request (level) from the register memory controller.
- RM_read  input  1  restore request (level) from the register memory controller.
- CTX_ID  input  CTX_W  target context slot; sampled on the request edge.
- RF_RADDR  output  5  register file read address, used during save.
- RF_RDATA  input  XLEN  register file combinational read data for RF_RADDR.
- RF_WADDR  output  5  register file write address, used during restore.
- RF_WDATA  output  XLEN  register file write data.
- RF_WEN  output  1  register file write enable.
- BUSY  output  1  high while a transfer is in progress.
- DONE  output  1  one-cycle pulse on transfer completion.
- ERR  output  1  one-cycle pulse with DONE when a restore hits an unwritten slot.

Behaviour:
- Reset: all outputs 0, FSM state IDLE, idx=0, VALID[NUM_CTX-1:0]=0, edge-detect registers=0. Memory array is not cleared; VALID gates its use.
- Request detect:
  - Registered copies of RM_write and RM_read; a start is a 0->1 transition seen in IDLE.
  - Level-held requests do not retrigger.
  - A request must drop low and rise again for a new transfer.
- Priority: simultaneous rising edges of RM_write and RM_read start SAVE; the restore is dropped.
- Requests rising while not IDLE are ignored and are not queued. The edge registers still track the inputs.
- On start: latch CTX_ID into ctx_q; idx=1.
- FSM states:
  - IDLE: wait for a start edge; SAVE on a write edge, RESTORE on a read edge.
  - SAVE: each cycle RF_RADDR=idx; at the clock edge mem[ctx_q][idx] <= RF_RDATA; idx++. After the idx=31 write, set VALID[ctx_q] and go to FIN. Occupies 31 cycles.
  - RESTORE: two-stage pipeline.
    - Cycle k registers rd_q <= mem[ctx_q][idx] and waddr_q <= idx.
    - Cycle k+1 drives RF_WEN=1, RF_WADDR=waddr_q, RF_WDATA=rd_q.
    - idx runs 1..31, then one drain cycle; 32 cycles in total.
    - If VALID[ctx_q]=0 at start: RF_WDATA=0 for every write, and set err_q.
  - FIN: DONE=1 for one cycle; ERR=err_q; clear err_q; return to IDLE.
- BUSY = (state != IDLE), including FIN.
- Registered outputs: BUSY is 1 in the cycle after the start edge is sampled. Latency from the request edge to the DONE pulse is 33 cycles (save) and 34 cycles (restore).
- x0: never read, never written to the register file, and never stored.
- RF_WEN=0 in all states other than RESTORE's write stage. RF_RADDR=0 outside SAVE.
- idx is 5 bits; it must never wrap to 0 inside a transfer.
- Reset mid-transfer:
  - Abort immediately: IDLE, outputs 0, no DONE.
  - VALID is cleared, so a partially saved slot is invalid.
- ctx_q stays fixed for the whole transfer; CTX_ID changes mid-transfer have no effect.
- Save to a slot that is already VALID overwrites it; VALID stays 1.

Test Plan:
- Reset, drive RF model xi=0x1000_0000+i, pulse RM_write with CTX_ID=2 -> BUSY next cycle, 31 RF reads on addresses 1..31, DONE 33 cycles after the edge, ERR=0, VALID[2]=1.
- Zero the RF model, RM_read with CTX_ID=2 -> 31 RF_WEN cycles on addresses 1..31 in order, data 0x1000_0001..0x1000_001F, address 0 never written, DONE at cycle 34, ERR=0.
- After reset, RM_read with CTX_ID=1 -> 31 writes of 0x0, then DONE and ERR pulse together for one cycle.
- RM_write and RM_read rise in the same cycle with CTX_ID=0 -> a save is performed, no RF_WEN is asserted, and a second RM_read edge during BUSY is ignored (exactly one DONE).
- RM_write held high for 100 cycles -> exactly one save and one DONE. Drop it low and raise it again -> a second save.
- Assert RESET at save cycle 10 -> next cycle BUSY=0, no DONE. A following restore of that slot returns zeros with ERR=1.
